mio_bus_responder: RTL and testbench

//  Memory/IO bus responder: the target side of the CPU's CPU_MIO / MIO_ready handshake.

---
 rtl/mio_bus_responder.sv | 163 ++++++++++++++++
 tb/tb_mio_bus_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : mio_bus_responder
// Description : Target side of the CPU_MIO/MIO_ready handshake. Decodes one
//               request at a time to block RAM, GPIO or a free-running counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mio_bus_responder #(
    parameter int RAM_LAT = 2,
    parameter int RAM_AW  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CPU_MIO,
    input  logic              mem_w,
    input  logic [31:0]       addr,
    input  logic [31:0]       Data_out,
    output logic [31:0]       Data_in,
    output logic              MIO_ready,
    output logic              bus_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw,
    output logic [31:0]       led
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] c_REG_RAM  = 2'd0;
    localparam logic [1:0] c_REG_GPIO = 2'd1;
    localparam logic [1:0] c_REG_CNT  = 2'd2;
    localparam logic [1:0] c_REG_NONE = 2'd3;

    localparam logic [29:0] c_GPIO_WADDR = 30'h3800_0000; // 0xE000_0000 >> 2
    localparam logic [29:0] c_CNT_WADDR  = 30'h3C00_0000; // 0xF000_0000 >> 2
    localparam logic [3:0]  c_WAIT_INIT  = 4'(RAM_LAT - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        region_q, region_d;
    logic              we_q, we_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_din_q, ram_din_d;
    logic [31:0]       data_in_q, data_in_d;
    logic [31:0]       led_q, led_d;
    logic [31:0]       count_q, count_d;

    logic [1:0]        w_region;
    logic              unused_addr_lsbs;

    // Byte offset within a word carries no meaning on this word-only bus.
    assign unused_addr_lsbs = &{1'b0, addr[1:0]};

    always_comb begin
        w_region = c_REG_NONE;
        if (addr[31:RAM_AW+2] == '0) begin
            w_region = c_REG_RAM;
        end else if (addr[31:2] == c_GPIO_WADDR) begin
            w_region = c_REG_GPIO;
        end else if (addr[31:2] == c_CNT_WADDR) begin
            w_region = c_REG_CNT;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        region_d   = region_q;
        we_d       = we_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        data_in_d  = data_in_q;
        led_d      = led_q;
        count_d    = count_q + 32'd1;

        case (state_q)
            ST_IDLE: begin
                if (CPU_MIO) begin
                    we_d     = mem_w;
                    region_d = w_region;
                    if (w_region == c_REG_RAM) begin
                        ram_addr_d = addr[RAM_AW+1:2];
                        ram_din_d  = Data_out;
                        cnt_d      = c_WAIT_INIT;
                        state_d    = ST_WAIT;
                    end else begin
                        // Peripheral side effects land on the accepting edge.
                        data_in_d = 32'h0;
                        state_d   = ST_DONE;
                        if (w_region == c_REG_GPIO) begin
                            if (mem_w) begin
                                led_d = Data_out;
                            end else begin
                                data_in_d = {16'h0, sw};
                            end
                        end else if (w_region == c_REG_CNT) begin
                            if (mem_w) begin
                                count_d = Data_out;
                            end else begin
                                data_in_d = count_q;
                            end
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    data_in_d = we_q ? 32'h0 : ram_dout;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            region_q   <= c_REG_RAM;
            we_q       <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= 32'h0;
            data_in_q  <= 32'h0;
            led_q      <= 32'h0;
            count_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            region_q   <= region_d;
            we_q       <= we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            data_in_q  <= data_in_d;
            led_q      <= led_d;
            count_q    <= count_d;
        end
    end

    // Gating with rst kills a strobe or completion in the cycle a reset aborts it.
    assign MIO_ready = (state_q == ST_DONE) && !rst;
    assign bus_err   = MIO_ready && (region_q == c_REG_NONE);
    assign ram_we    = (state_q == ST_WAIT) && (cnt_q == 4'd0) && we_q && !rst;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign Data_in   = data_in_q;
    assign led       = led_q;

endmodule
`default_nettype wire

// File: tb/tb_mio_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mio_bus_responder
// Description : Randomized bench for mio_bus_responder against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mio_bus_responder;

    localparam int RAM_LAT = 2;
    localparam int RAM_AW  = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        CPU_MIO = 1'b0;
    logic        mem_w = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] Data_out = 32'h0;
    logic [31:0] Data_in;
    logic        MIO_ready;
    logic        bus_err;
    logic [RAM_AW-1:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_din;
    logic [31:0] ram_dout = 32'h0;
    logic [15:0] sw = 16'h0;
    logic [31:0] led;

    mio_bus_responder #(.RAM_LAT(RAM_LAT), .RAM_AW(RAM_AW)) u_dut (
        .clk(clk), .rst(rst), .CPU_MIO(CPU_MIO), .mem_w(mem_w), .addr(addr),
        .Data_out(Data_out), .Data_in(Data_in), .MIO_ready(MIO_ready),
        .bus_err(bus_err), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_din(ram_din), .ram_dout(ram_dout), .sw(sw), .led(led)
    );

    always #5 clk = ~clk;

    // Synchronous-read block RAM seen by the DUT
    logic [31:0] env_mem [1024] = '{default: 32'h0};
    always @(posedge clk) begin
        if (ram_we) env_mem[ram_addr] <= ram_din;
        ram_dout <= env_mem[ram_addr];
    end

    // Transaction-level reference state
    logic [31:0] ref_mem [1024] = '{default: 32'h0};
    logic [31:0] ref_led = 32'h0;
    logic [31:0] cnt_base = 32'h0;
    int          cnt_base_edge = 0;
    int          edge_no = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_no++;
        #1;
    endtask

    function automatic int classify(input logic [31:0] a);
        if (a < 32'h0000_1000)                 return 0;
        if ((a & 32'hFFFF_FFFC) == 32'hE000_0000) return 1;
        if ((a & 32'hFFFF_FFFC) == 32'hF000_0000) return 2;
        return 3;
    endfunction

    task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d);
        int          rg, lat, k, we_cnt, e;
        logic [31:0] exp_data, we_din;
        logic [RAM_AW-1:0] we_addr;
        logic [15:0] sw_at;
        rg = classify(a);
        CPU_MIO = 1'b1; mem_w = w; addr = a; Data_out = d;
        tick();
        e = edge_no;
        sw_at = sw;
        exp_data = 32'h0;
        lat = (rg == 0) ? RAM_LAT + 1 : 1;
        case (rg)
            0: if (w) ref_mem[a[11:2]] = d; else exp_data = ref_mem[a[11:2]];
            1: if (w) ref_led = d; else exp_data = {16'h0, sw_at};
            2: if (w) begin cnt_base = d; cnt_base_edge = e; end
               else exp_data = cnt_base + 32'(e - 1 - cnt_base_edge);
            default: ;
        endcase
        // Request lines wander after acceptance; the DUT must not notice.
        mem_w = 1'($urandom); addr = $urandom; Data_out = $urandom; sw = 16'($urandom);
        we_cnt = 0; we_addr = '0; we_din = 32'h0; k = 0;
        forever begin
            k++;
            if (ram_we) begin
                we_cnt++; we_addr = ram_addr; we_din = ram_din;
            end
            if (MIO_ready || k >= 40) break;
            tick();
        end
        check("latency", 32'(k), 32'(lat));
        if (MIO_ready) begin
            check("bus_err", {31'h0, bus_err}, {31'h0, rg == 3});
            if (!w) check("load_data", Data_in, exp_data);
            check("led", led, ref_led);
        end
        check("ram_we_count", 32'(we_cnt), (rg == 0 && w) ? 32'd1 : 32'd0);
        if (rg == 0 && w && we_cnt == 1) begin
            check("ram_addr", {22'h0, we_addr}, {22'h0, a[11:2]});
            check("ram_din", we_din, d);
        end
        CPU_MIO = 1'b0;
        tick();
        check("ready_low", {31'h0, MIO_ready}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, adj;
        bit prev;
        // Reset with a request pending: nothing may be accepted
        rst = 1'b1; CPU_MIO = 1'b1; addr = 32'hE000_0000;
        tick();
        check("rst_ready", {31'h0, MIO_ready}, 32'h0);
        tick();
        check("rst_ready2", {31'h0, MIO_ready}, 32'h0);
        check("rst_led", led, 32'h0);
        check("rst_data_in", Data_in, 32'h0);
        check("rst_we", {31'h0, ram_we}, 32'h0);
        check("rst_ram_addr", {22'h0, ram_addr}, 32'h0);
        check("rst_ram_din", ram_din, 32'h0);
        CPU_MIO = 1'b0; rst = 1'b0;
        cnt_base = 32'h0; cnt_base_edge = edge_no;
        tick();
        check("post_rst_idle", {31'h0, MIO_ready}, 32'h0);
        tick();
        check("post_rst_idle2", {31'h0, MIO_ready}, 32'h0);

        // Counter right after reset, then directed cases
        do_req(1'b0, 32'hF000_0000, 32'h0);
        do_req(1'b1, 32'h0000_0010, 32'h1234_5678);
        do_req(1'b0, 32'h0000_0010, 32'h0);
        sw = 16'hA5A5;
        do_req(1'b0, 32'hE000_0000, 32'h0);
        do_req(1'b1, 32'hE000_0000, 32'h0000_00FF);
        do_req(1'b1, 32'hF000_0000, 32'hFFFF_FFFE);
        tick();
        do_req(1'b0, 32'hF000_0000, 32'h0);
        do_req(1'b0, 32'h8000_0000, 32'h0);
        do_req(1'b1, 32'h8000_0000, 32'hDEAD_0001);
        do_req(1'b1, 32'h0000_0FFC, 32'hCAFE_F00D);
        do_req(1'b0, 32'h0000_0FFE, 32'h0);
        do_req(1'b1, 32'h0000_1000, 32'h5555_5555);
        do_req(1'b0, 32'hE000_0004, 32'h0);
        do_req(1'b0, 32'h0000_0010, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            int rg;
            logic [31:0] a;
            rg = $urandom_range(0, 3);
            case (rg)
                0: a = 32'($urandom_range(0, 63) << 2) | 32'($urandom_range(0, 3));
                1: a = 32'hE000_0000 | 32'($urandom_range(0, 3));
                2: a = 32'hF000_0000 | 32'($urandom_range(0, 3));
                default: begin
                    a = $urandom;
                    while (classify(a) != 3) a = $urandom;
                end
            endcase
            sw = 16'($urandom);
            do_req(1'($urandom), a, $urandom);
            repeat ($urandom_range(0, 2)) tick();
        end

        // Reset in the store's strobe cycle aborts it
        CPU_MIO = 1'b1; mem_w = 1'b1; addr = 32'h0000_0200; Data_out = 32'hDEAD_BEEF;
        tick();
        CPU_MIO = 1'b0;
        repeat (RAM_LAT - 1) tick();
        rst = 1'b1;
        #1;
        check("abort_we", {31'h0, ram_we}, 32'h0);
        check("abort_ready", {31'h0, MIO_ready}, 32'h0);
        tick();
        check("abort_ready2", {31'h0, MIO_ready}, 32'h0);
        rst = 1'b0;
        ref_led = 32'h0;
        cnt_base = 32'h0; cnt_base_edge = edge_no;
        tick();
        check("abort_idle", {31'h0, MIO_ready}, 32'h0);
        do_req(1'b0, 32'h0000_0200, 32'h0);
        do_req(1'b0, 32'hF000_0000, 32'h0);

        // CPU_MIO held high: one completion every two cycles
        CPU_MIO = 1'b1; mem_w = 1'b0; addr = 32'hE000_0000;
        pulses = 0; adj = 0; prev = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (MIO_ready) pulses++;
            if (MIO_ready && prev) adj++;
            prev = MIO_ready;
        end
        CPU_MIO = 1'b0;
        tick();
        check("b2b_pulses", 32'(pulses), 32'd6);
        check("b2b_adjacent", 32'(adj), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
